// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up and a one-cycle done strobe.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_SIGN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   rs1_q, rs2_q;
  logic [XLEN-1:0]   opa;
  logic [2*XLEN-1:0] acc;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   res_pend;
  logic [XLEN-1:0]   result_q;

  logic              sgn1, sgn2, s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_val;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rem;
  logic              div_ok;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] acc_nx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   sign_val;

  always_comb begin
    sgn1 = op_q[2] ? !op_q[0] : (op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10);
    sgn2 = op_q[2] ? !op_q[0] : (op_q[1:0] == 2'b01);
    s1   = sgn1 & rs1_q[XLEN-1];
    s2   = sgn2 & rs2_q[XLEN-1];
    mag1 = s1 ? -rs1_q : rs1_q;
    mag2 = s2 ? -rs2_q : rs2_q;

    div_zero = (rs2_q == '0);
    div_ovf  = op_q[2] && !op_q[0] && (rs2_q == '1) &&
               (rs1_q == {1'b1, {(XLEN-1){1'b0}}});
    special  = op_q[2] && (div_zero || div_ovf);
    if (div_zero)
      special_val = op_q[1] ? rs1_q : '1;
    else
      special_val = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Remainder is carried one bit wider during the trial subtract so a divisor
  // with its MSB set cannot lose the bit shifted out of the remainder.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
    div_rem  = acc[2*XLEN-1:XLEN-1];
    div_ok   = (div_rem >= {1'b0, opa});
    div_diff = div_rem[XLEN-1:0] - opa;
    if (op_q[2])
      acc_nx = div_ok ? {div_diff, acc[XLEN-2:0], 1'b1}
                      : {div_rem[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      acc_nx = {mul_sum, acc[XLEN-1:1]};
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 sign_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sign_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         sign_val = quot;
      default:                sign_val = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      opa      <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      res_pend <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !kill) begin
            op_q  <= op;
            rs1_q <= rs1;
            rs2_q <= rs2;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          cnt   <= CW'(XLEN - 1);
          neg_q <= s1 ^ s2;
          neg_r <= s1;
          if (op_q[2]) begin
            acc <= {{XLEN{1'b0}}, mag1};
            opa <= mag2;
          end else begin
            acc <= {{XLEN{1'b0}}, mag2};
            opa <= mag1;
          end
          if (special) begin
            res_pend <= special_val;
            state    <= S_DONE;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= acc_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= S_SIGN;
        end
        S_SIGN: begin
          res_pend <= sign_val;
          state    <= S_DONE;
        end
        S_DONE: begin
          if (!kill)
            result_q <= res_pend;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (kill && state != S_IDLE)
        state <= S_IDLE;
    end
  end

  // The DONE-cycle value is forwarded so it is visible with the strobe, while a
  // kill in that cycle leaves the previously held result in place.
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE) && !kill;
  assign result = done ? res_pend : result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic results, latency, special cases,
// kill/start interaction and asynchronous reset mid-operation.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge of cycle 1 (start sampled at edge 0).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int start_at);
    int cyc;
    issue(o, a, b);
    chk({tag, "_busy1"}, {31'b0, busy}, 32'd1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == start_at) begin
        start = 1'b1; op = 3'b011; rs1 = 32'h1234_5678; rs2 = 32'h0000_0100;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_res"}, result, exp);
    @(negedge clk);
    chk({tag, "_done1cyc"}, {31'b0, done}, 32'd0);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    chk({tag, "_held"}, result, exp);
  endtask

  initial begin
    int seen;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    #20 rst_n = 1'b1;

    run_op("mul_ff",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 35, 0);
    run_op("mulhu_ff",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 0);
    run_op("mulh_m2",   3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 35, 0);
    run_op("mulhsu_m2", 3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 35, 0);
    run_op("mul_m2",    3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 35, 0);
    run_op("div_m7",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 35, 0);
    run_op("rem_m7",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 35, 0);
    run_op("divu_m7",   3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 35, 0);
    run_op("remu_m7",   3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 35, 0);
    run_op("divu_big",  3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 35, 0);
    run_op("remu_big",  3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 35, 0);

    run_op("divu_z",    3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2, 0);
    run_op("remu_z",    3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 2, 0);
    run_op("div_z",     3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 2, 0);
    run_op("rem_z",     3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 2, 0);
    run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
    run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 0);

    // start pulse while busy must be ignored
    run_op("div_ign",   3'b100, 32'd100, 32'd7, 32'h0000_000E, 35, 5);

    // kill at cycle 10 of a DIV
    issue(3'b100, 32'hFFFF_FFF9, 32'h0000_0002);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_result", result, 32'h0000_000E);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("kill_nodone", 32'(seen), 32'd0);

    // start and kill together in IDLE
    @(negedge clk);
    op = 3'b101; rs1 = 32'd5; rs2 = 32'd0; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("sk_busy", {31'b0, busy}, 32'd0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("sk_quiet", 32'(seen), 32'd0);

    // kill coinciding with the DONE cycle
    issue(3'b101, 32'd5, 32'd0);
    @(negedge clk);
    chk("kd_done_pre", {31'b0, done}, 32'd1);
    kill = 1'b1;
    #1;
    chk("kd_done_gated", {31'b0, done}, 32'd0);
    chk("kd_result_gated", result, 32'h0000_000E);
    @(negedge clk);
    kill = 1'b0;
    chk("kd_busy", {31'b0, busy}, 32'd0);
    chk("kd_result_held", result, 32'h0000_000E);

    // asynchronous reset at cycle 20 of a MUL
    issue(3'b000, 32'h1234_5678, 32'h0000_0010);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_after", 3'b000, 32'd6, 32'd7, 32'd42, 35, 0);
    run_op("mulhu_after", 3'b011, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 35, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
